// File: rtl/sort_sequencer.sv
// sort_sequencer: buffers a signed burst, bubble-sorts it with one shared comparator, streams it out ascending.
// comparator_lt: signed a < b, resolving sign mismatch before the magnitude compare so no overflow is possible.

module comparator_lt #(
   parameter int N = 32
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         lt
);
   assign lt = (a[N-1] != b[N-1]) ? a[N-1] : (a[N-2:0] < b[N-2:0]);
endmodule

module sort_sequencer #(
   parameter int N     = 32,
   parameter int DEPTH = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_data,
   input  logic         in_last,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_data,
   output logic         out_last,
   output logic         busy
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;

   state_t        state;
   logic [N-1:0]  mem [DEPTH];
   logic [CW-1:0] count;
   logic [AW-1:0] i, i1, limit, rd;
   logic          swapped, lt, load_hs, burst_end;

   assign i1        = i + AW'(1);
   assign load_hs   = in_ready && in_valid;
   assign burst_end = in_last || (count == CW'(DEPTH - 1));
   assign out_data  = mem[rd];
   assign out_last  = out_valid && (CW'(rd) == count - CW'(1));

   comparator_lt #(.N(N)) u_cmp (.a(mem[i1]), .b(mem[i]), .lt(lt));

   // Buffer has no reset: its contents only matter once count says they were loaded.
   always_ff @(posedge clk) begin
      if (load_hs)
         mem[AW'(count)] <= in_data;
      else if (state == SORT && lt) begin
         mem[i]  <= mem[i1];
         mem[i1] <= mem[i];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= LOAD;
         count     <= '0;
         i         <= '0;
         limit     <= '0;
         rd        <= '0;
         swapped   <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            LOAD: begin
               if (load_hs) begin
                  count <= count + CW'(1);
                  if (burst_end) begin
                     state     <= (count == '0) ? DRAIN : SORT;
                     in_ready  <= 1'b0;
                     busy      <= (count != '0);
                     out_valid <= (count == '0);
                     limit     <= AW'(count);
                     i         <= '0;
                     swapped   <= 1'b0;
                     rd        <= '0;
                  end
               end
            end
            SORT: begin
               swapped <= swapped | lt;
               if (i < limit - AW'(1))
                  i <= i1;
               else if (limit == AW'(1) || !(swapped || lt)) begin
                  state     <= DRAIN;
                  busy      <= 1'b0;
                  out_valid <= 1'b1;
                  rd        <= '0;
               end else begin
                  limit   <= limit - AW'(1);
                  i       <= '0;
                  swapped <= 1'b0;
               end
            end
            DRAIN: begin
               if (out_ready) begin
                  if (out_last) begin
                     count     <= '0;
                     state     <= LOAD;
                     out_valid <= 1'b0;
                     in_ready  <= 1'b1;
                  end else
                     rd <= rd + AW'(1);
               end
            end
            default: state <= LOAD;
         endcase
      end
   end
endmodule

// File: tb/tb_sort_sequencer.sv
// tb_sort_sequencer: directed bursts checked against a queue-based sorted model and a bubble-pass cycle model.
module tb_sort_sequencer;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_data = '0;
   logic        in_last = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_data;
   logic        out_last;
   logic        busy;

   int total = 0;
   int bad = 0;
   int busy_cnt = 0;
   bit toggle = 1'b0;
   bit after_last = 1'b0;
   int stim[$];
   int exp_q[$];

   sort_sequencer #(.N(32), .DEPTH(8)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h", name, act, exp);
      end
   endtask

   function automatic void sorted_model(input int a[$], output int q[$]);
      q = {};
      foreach (a[k]) begin
         int p = 0;
         while (p < q.size() && q[p] <= a[k]) p++;
         q.insert(p, a[k]);
      end
   endfunction

   function automatic int bubble_cycles(input int a[$]);
      int lim = a.size() - 1;
      int cyc = 0;
      bit sw;
      if (a.size() < 2) return 0;
      forever begin
         sw = 0;
         for (int j = 0; j < lim; j++) begin
            cyc++;
            if (a[j+1] < a[j]) begin
               int t = a[j]; a[j] = a[j+1]; a[j+1] = t; sw = 1;
            end
         end
         if (lim == 1 || !sw) return cyc;
         lim--;
      end
   endfunction

   always @(posedge clk) begin
      #1;
      out_ready = toggle ? !out_ready : 1'b1;
   end

   always @(negedge clk) if (busy) busy_cnt++;

   always @(negedge clk) begin
      if (rst) begin
         if (after_last) begin
            chk("in_ready_after_last", {31'b0, in_ready}, 32'd1);
            chk("out_valid_after_last", {31'b0, out_valid}, 32'd0);
            after_last = 1'b0;
         end
         if (out_valid) begin
            if (exp_q.size() == 0)
               chk("spurious_out_valid", {31'b0, out_valid}, 32'd0);
            else begin
               chk("out_data", out_data, 32'(exp_q[0]));
               chk("out_last", {31'b0, out_last}, {31'b0, exp_q.size() == 1});
               chk("in_ready_in_drain", {31'b0, in_ready}, 32'd0);
               if (out_ready) begin
                  after_last = out_last;
                  void'(exp_q.pop_front());
               end
            end
         end
      end
   end

   task automatic burst(input bit use_last);
      busy_cnt = 0;
      for (int k = 0; k < stim.size(); k++) begin
         int t = 0;
         @(posedge clk); #1;
         in_valid = 1'b1;
         in_data  = 32'(stim[k]);
         in_last  = use_last && (k == stim.size() - 1);
         @(negedge clk);
         while (!in_ready && t < 100) begin @(negedge clk); t++; end
         chk("load_accept", {31'b0, in_ready}, 32'd1);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      sorted_model(stim, exp_q);
   endtask

   task automatic drain_and_check(input string name, input int lit_busy);
      int m = bubble_cycles(stim);
      for (int k = 0; k < 300 && (exp_q.size() != 0 || out_valid); k++) @(negedge clk);
      @(negedge clk);
      chk({name, "_drained"}, 32'(exp_q.size()), 32'd0);
      chk({name, "_busy_model"}, 32'(busy_cnt), 32'(m));
      chk({name, "_busy_literal"}, 32'(busy_cnt), 32'(lit_busy));
   endtask

   initial begin
      #12;
      chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
      chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
      chk("reset_out_last", {31'b0, out_last}, 32'd0);
      chk("reset_busy", {31'b0, busy}, 32'd0);
      #10 rst = 1'b1;

      stim = '{5, 4, 3, 2, 1, 0, -1, -2};
      burst(1'b1);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      exp_q = {};
      after_last = 1'b0;
      #1;
      chk("midsort_rst_in_ready", {31'b0, in_ready}, 32'd1);
      chk("midsort_rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("midsort_rst_busy", {31'b0, busy}, 32'd0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;

      stim = '{3, 1, 2};
      burst(1'b1);
      drain_and_check("after_reset", 3);

      stim = '{7, 6, 5, 4, 3, 2, 1, 0};
      burst(1'b0);
      drain_and_check("reverse_full", 28);

      stim = '{32'h7FFFFFFF, 32'h80000000, 0, -1};
      burst(1'b1);
      chk("extreme_model_first", 32'(exp_q[0]), 32'h80000000);
      chk("extreme_model_last", 32'(exp_q[3]), 32'h7FFFFFFF);
      drain_and_check("extremes", 6);

      stim = '{1, 2, 2, 3};
      burst(1'b1);
      drain_and_check("presorted_dups", 3);

      stim = '{42};
      burst(1'b1);
      drain_and_check("single", 0);

      toggle = 1'b1;
      stim = '{9, -9};
      burst(1'b1);
      chk("bp_model_first", 32'(exp_q[0]), 32'hFFFFFFF7);
      drain_and_check("backpressure", 1);
      toggle = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/sort_sequencer.md
Name: sort_sequencer

Overview:
- Buffers a burst of up to DEPTH signed words, sorts them into ascending two's-complement order, then streams them out.
- Sorting is a bubble sort driven by one shared instance of the team's structural signed less-than comparator, comparator_lt, which is parameterised to width N.
- The block is the sequencing controller for that comparator: the comparator is the only compare resource, and it is used once per cycle.
- Sits between a valid/ready producer and a valid/ready consumer in the HW datapath.

Parameters:
- N, 32, data word width; signed two's complement.
- DEPTH, 8, maximum words per burst; must be 2 or more.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  producer has a word on in_data.
- in_ready  output  1  block accepts a word this cycle.
- in_data  input  N  signed word to load.
- in_last  input  1  marks the final word of a burst; qualified by in_valid && in_ready.
- out_valid  output  1  out_data holds a sorted word.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  N  sorted word, smallest first.
- out_last  output  1  marks the final word of the sorted burst.
- busy  output  1  high in the SORT state.

Behaviour:
- States: LOAD, SORT, DRAIN.
- Reset (rst low, async): state=LOAD, count=0, all indices=0, swapped=0, in_ready=1, out_valid=0, out_last=0, busy=0. Buffer contents are don't-care.
- An assertion of rst at any time aborts load, sort or drain immediately. Partially loaded data is discarded.
- LOAD:
  - in_ready=1.
  - On handshake: mem[count] <= in_data, count++.
  - Exit when the handshake carries in_last=1, or when count reaches DEPTH (the DEPTH-th word forces the end of the burst even if in_last=0).
  - Exit goes to SORT with limit=count-1, i=0, swapped=0.
  - A burst of one word skips SORT and goes straight to DRAIN.
- SORT:
  - in_ready=0, busy=1.
  - Each cycle the comparator evaluates mem[i+1] < mem[i] (a=mem[i+1], b=mem[i]).
  - If true: swap the two entries and set swapped=1. Equal values are never swapped, so the sort is stable.
  - If i < limit-1: i++.
  - Otherwise the pass ends:
    - If limit==1 or no swap occurred in the pass (including a swap this cycle), go to DRAIN with rd=0.
    - Else limit--, i=0, swapped=0.
  - Worst case: count*(count-1)/2 cycles in SORT. Already-sorted input: count-1 cycles.
- DRAIN:
  - out_valid=1, out_data=mem[rd], out_last=(rd==count-1).
  - On out_valid && out_ready: rd++.
  - On the handshake with out_last: count=0, go to LOAD. in_ready rises the next cycle, so there is no overlap with loading.
  - out_data must remain stable while out_valid=1 && out_ready=0.
- Outputs are registered-state decodes; no combinational path from in_* to out_*.
- Signed rules: 0x80000000 (most negative) sorts first and 0x7FFFFFFF sorts last. Overflow-prone pairs must compare correctly, because the comparator handles sign mismatch explicitly.
- in_valid while in SORT or DRAIN is ignored; the producer holds the word.

Test Plan:
- Reset mid-SORT: load {5,4,3,2,1,0,-1,-2}, assert rst low 3 cycles into SORT → immediately in_ready=1, out_valid=0, busy=0. Then load {3,1,2} with last → output 1,2,3.
- Full reverse burst: load 8 words {7,6,5,4,3,2,1,0} (no in_last) → exactly 28 busy cycles, then output 0..7, with out_last on 7.
- Signed extremes: {0x7FFFFFFF, 0x80000000, 0, -1 (0xFFFFFFFF)} with last → output 0x80000000, 0xFFFFFFFF, 0, 0x7FFFFFFF.
- Presorted and duplicates: {1,2,2,3} → busy for 3 cycles only, output 1,2,2,3. Single word {42} with last → no busy, output 42 with out_last=1.
- Backpressure: drain {9,-9} with out_ready toggling 0/1 each cycle → out_data holds each value while stalled, order -9 then 9. in_ready stays 0 until the cycle after the last handshake.
